// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO controller: instruction opcodes and FSM states.
// Imported by hilo_ctrl and anything decoding HI/LO-class instructions.
package hilo_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    // Opcodes 0..3 are the ones that launch multdiv.
    function automatic logic is_md_op(input logic [2:0] code);
        return ~code[2];
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO registers plus issue/interlock for multdiv: ops accepted in IDLE, md_start one cycle later.
// Writeback at first BUSY edge with md_run low; stall holds EX while any valid op meets a non-IDLE FSM.
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    input  logic          flush,
    input  logic [2:0]    op,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    output logic          stall,
    output logic [DW-1:0] result,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          div0,
    output logic          md_start,
    output logic          md_multdivb,
    output logic          md_signedop,
    output logic [DW-1:0] md_x,
    output logic [DW-1:0] md_y,
    input  logic [DW-1:0] md_prodh,
    input  logic [DW-1:0] md_prodl,
    input  logic          md_run
);

    state_t state;
    state_t state_nxt;

    logic v;
    logic idle;
    logic accept;
    logic md_accept;
    logic writeback;

    assign v         = op_valid & ~flush;
    assign idle      = (state == IDLE);
    assign accept    = v & idle;
    assign md_accept = accept & is_md_op(op);
    assign writeback = (state == BUSY) & ~md_run;
    assign stall     = v & ~idle;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md_accept) state_nxt = START;
            START:   state_nxt = BUSY;
            BUSY:    if (!md_run) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MFxx reads the architectural registers only; no bypass from multdiv.
    always_comb begin
        result = '0;
        if (v) begin
            case (op)
                OP_MFHI: result = hi;
                OP_MFLO: result = lo;
                default: result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_start    <= 1'b0;
            md_multdivb <= 1'b0;
            md_signedop <= 1'b0;
            md_x        <= '0;
            md_y        <= '0;
            div0        <= 1'b0;
        end else begin
            md_start <= md_accept;
            if (md_accept) begin
                md_x        <= rs_val;
                md_y        <= rt_val;
                md_multdivb <= ~op[1];
                md_signedop <= ~op[0];
                div0        <= op[1] & (rt_val == '0);
            end
        end
    end

    // Writeback and MTxx cannot coincide: MTxx is only accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (writeback) begin
            hi <= md_prodh;
            lo <= md_prodl;
        end else if (accept && op == OP_MTHI) begin
            hi <= rs_val;
        end else if (accept && op == OP_MTLO) begin
            lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed test-plan sequences followed by random traffic, checked against a transaction-level model.
// A behavioural multdiv with random latency answers md_start.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    logic        md_start;
    logic        md_multdivb;
    logic        md_signedop;
    logic [31:0] md_x;
    logic [31:0] md_y;
    logic [31:0] md_prodh = '0;
    logic [31:0] md_prodl = '0;
    logic        md_run = 1'b0;

    hilo_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .flush       (flush),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .stall       (stall),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .div0        (div0),
        .md_start    (md_start),
        .md_multdivb (md_multdivb),
        .md_signedop (md_signedop),
        .md_x        (md_x),
        .md_y        (md_y),
        .md_prodh    (md_prodh),
        .md_prodl    (md_prodl),
        .md_run      (md_run)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: architectural view plus one in-flight operation.
    logic [31:0] exp_hi = '0, exp_lo = '0, exp_x = '0, exp_y = '0;
    logic [31:0] pend_h = '0, pend_l = '0;
    logic        exp_div0 = 0, exp_mdb = 0, exp_sgn = 0, exp_start = 0;
    bit          busy = 0, launched = 0, accepted = 0, last_stall = 0;
    logic [31:0] last_res = '0;
    int          n_start = 0;
    int          force_lat = 0;
    int          mcnt = 0;
    logic [63:0] mres;

    function automatic logic [63:0] md_compute(input logic mul, input logic sgn,
                                               input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, ay, q, r;
        if (mul) begin
            if (sgn) return {{32{x[31]}}, x} * {{32{y[31]}}, y};
            return {32'd0, x} * {32'd0, y};
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        ax = (sgn && x[31]) ? -x : x;
        ay = (sgn && y[31]) ? -y : y;
        q  = ax / ay;
        r  = ax % ay;
        if (sgn && (x[31] ^ y[31])) q = -q;
        if (sgn && x[31]) r = -r;
        return {r, q};
    endfunction

    // multdiv stand-in: garbage on the product bus until md_run falls.
    always @(negedge clk) begin
        if (reset) begin
            md_run = 1'b0;
            mcnt   = 0;
        end else if (md_start) begin
            mres     = md_compute(md_multdivb, md_signedop, md_x, md_y);
            mcnt     = (force_lat != 0) ? force_lat : $urandom_range(1, 6);
            md_run   = 1'b1;
            md_prodh = $urandom;
            md_prodl = $urandom;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                md_run   = 1'b0;
                md_prodh = mres[63:32];
                md_prodl = mres[31:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_hi = '0; exp_lo = '0; exp_x = '0; exp_y = '0;
        exp_div0 = 0; exp_mdb = 0; exp_sgn = 0; exp_start = 0;
        busy = 0; launched = 0; last_stall = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers.
    task automatic cycle(input logic ov, input logic fl, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        logic vv;
        logic [31:0] er;
        op_valid = ov; flush = fl; op = o; rs_val = a; rt_val = b;
        #1;
        vv = ov & ~fl;
        er = (vv && o == 3'd4) ? exp_hi : (vv && o == 3'd5) ? exp_lo : 32'd0;
        chk("stall", {31'd0, stall}, {31'd0, vv & busy});
        chk("result", result, er);
        last_res   = result;
        last_stall = vv & busy;
        @(posedge clk);
        accepted = 0;
        if (busy) begin
            if (launched && !md_run) begin
                exp_hi = pend_h;
                exp_lo = pend_l;
                busy   = 0;
            end else begin
                launched = 1;
            end
        end else if (vv) begin
            accepted = 1;
            if (!o[2]) begin
                busy     = 1;
                launched = 0;
                {pend_h, pend_l} = md_compute(~o[1], ~o[0], a, b);
                exp_x = a; exp_y = b; exp_mdb = ~o[1]; exp_sgn = ~o[0];
                exp_div0 = o[1] && (b == 32'd0);
            end else if (o == 3'd6) begin
                exp_hi = a;
            end else if (o == 3'd7) begin
                exp_lo = a;
            end
        end
        exp_start = accepted & ~o[2];
        #1;
        if (md_start) n_start++;
        chk("md_start", {31'd0, md_start}, {31'd0, exp_start});
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("div0", {31'd0, div0}, {31'd0, exp_div0});
        chk("md_x", md_x, exp_x);
        chk("md_y", md_y, exp_y);
        chk("md_multdivb", {31'd0, md_multdivb}, {31'd0, exp_mdb});
        chk("md_signedop", {31'd0, md_signedop}, {31'd0, exp_sgn});
        @(negedge clk);
    endtask

    // Hold an instruction until accepted; returns how many cycles it took.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        cycles = 0;
        accepted = 0;
        while (!accepted && cycles < 60) begin
            cycle(1'b1, 1'b0, o, a, b);
            cycles++;
        end
        chk("accept_bound", {31'd0, accepted}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    int nc;
    int s0;
    logic       rv, rf;
    logic [2:0] ro = 3'd0;
    logic [31:0] ra = '0, rb = '0;

    initial begin
        // Reset state
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_md_start", {31'd0, md_start}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // MULT -2 x 3, MFLO held behind it
        s0 = n_start;
        run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, nc);
        chk("t1_sgn", {31'd0, md_signedop}, 32'd1);
        run_op(3'd5, 32'd0, 32'd0, nc);
        chk("t1_stalled", {31'd0, nc > 2}, 32'd1);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFFA);
        chk("t1_res", last_res, 32'hFFFF_FFFA);
        chk("t1_pulses", n_start - s0, 32'd1);

        // DIVU 7 / 2, then MFHI
        run_op(3'd3, 32'd7, 32'd2, nc);
        run_op(3'd4, 32'd0, 32'd0, nc);
        chk("t2_hi", hi, 32'd1);
        chk("t2_lo", lo, 32'd3);
        chk("t2_res", last_res, 32'd1);
        chk("t2_div0", {31'd0, div0}, 32'd0);

        // MTHI then MFHI, both without stall
        run_op(3'd6, 32'h1234_5678, 32'd0, nc);
        chk("t3_mthi_cyc", nc, 32'd1);
        run_op(3'd4, 32'd0, 32'd0, nc);
        chk("t3_mfhi_cyc", nc, 32'd1);
        chk("t3_res", last_res, 32'h1234_5678);
        chk("t3_lo", lo, 32'd3);

        // MULTU immediately followed by DIV
        s0 = n_start;
        run_op(3'd1, 32'h8000_0000, 32'd2, nc);
        run_op(3'd2, 32'hFFFF_FFF7, 32'd2, nc);
        chk("t4_hi_first", hi, 32'd1);
        chk("t4_lo_first", lo, 32'd0);
        run_op(3'd5, 32'd0, 32'd0, nc);
        chk("t4_quot", last_res, 32'hFFFF_FFFC);
        chk("t4_rem", hi, 32'hFFFF_FFFF);
        chk("t4_pulses", n_start - s0, 32'd2);

        // Divide by zero
        run_op(3'd2, 32'd5, 32'd0, nc);
        chk("t5_div0", {31'd0, div0}, 32'd1);
        run_op(3'd4, 32'd0, 32'd0, nc);
        chk("t5_released", {31'd0, stall}, 32'd0);

        // Reset while BUSY
        force_lat = 20;
        run_op(3'd0, 32'd9, 32'd9, nc);
        cycle(1'b1, 1'b0, 3'd5, 32'd0, 32'd0);
        cycle(1'b1, 1'b0, 3'd5, 32'd0, 32'd0);
        reset = 1'b1;
        md_run = 1'b0;
        mcnt = 0;
        #1;
        chk("t6_stall", {31'd0, stall}, 32'd0);
        chk("t6_md_start", {31'd0, md_start}, 32'd0);
        chk("t6_hi", hi, 32'd0);
        chk("t6_lo", lo, 32'd0);
        chk("t6_md_x", md_x, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        force_lat = 0;
        run_op(3'd5, 32'd0, 32'd0, nc);
        chk("t6_mflo_cyc", nc, 32'd1);
        chk("t6_mflo_res", last_res, 32'd0);

        // Random traffic; a stalled instruction is held unless flushed
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                rv = ($urandom_range(0, 3) != 0);
                ro = 3'($urandom_range(0, 7));
                ra = $urandom;
                rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            end
            rf = ($urandom_range(0, 9) == 0);
            cycle(rv, rf, ro, ra, rb);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
